// File: rtl/btn_cond.sv
// Pushbutton conditioner: synchronise, debounce on a slow tick, emit press/release/repeat pulses.
// Optional auto-repeat hold FSM is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_cond #(
  parameter int N_SW     = 3,
  parameter int TICK_DIV = 500000,
  parameter int DB_CNT   = 4,
  parameter int REP_DLY  = 50,
  parameter int REP_PER  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_level,
  output logic [N_SW-1:0] o_press,
  output logic [N_SW-1:0] o_release,
  output logic [N_SW-1:0] o_repeat
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(DB_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] DB_LAST   = SW'(DB_CNT - 1);

  logic [N_SW-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0]            tick_cnt_q, tick_cnt_d;
  logic [N_SW-1:0][SW-1:0]  stab_q, stab_d;
  logic [N_SW-1:0]          level_q, level_d;
  logic [N_SW-1:0]          press_q, press_d;
  logic [N_SW-1:0]          release_q, release_d;
  logic [N_SW-1:0]          s;
  logic                     tick;

  assign s    = ~sync2_q;
  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    sync1_d = i_sw;
    sync2_d = sync1_q;
    if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // A flip needs DB_CNT consecutive differing tick samples; an agreeing sample restarts the count.
  always_comb begin
    level_d   = level_q;
    stab_d    = stab_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (tick && (s[i] != level_q[i])) begin
        if (stab_q[i] == DB_LAST) begin
          level_d[i]   = s[i];
          stab_d[i]    = '0;
          press_d[i]   = s[i];
          release_d[i] = ~s[i];
        end else begin
          stab_d[i] = stab_q[i] + SW'(1);
        end
      end else if (tick) begin
        stab_d[i] = '0;
      end else begin
        stab_d[i] = stab_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      tick_cnt_q <= '0;
      stab_q     <= '0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      stab_q     <= stab_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int HMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REP_DLY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REP_PER - 1);

  typedef enum logic [1:0] {H_REL = 2'd0, H_WAIT = 2'd1, H_RPT = 2'd2} hold_t;

  hold_t                   state_q [N_SW];
  hold_t                   state_d [N_SW];
  logic [N_SW-1:0][HW-1:0] hold_q, hold_d;
  logic [N_SW-1:0]         rep_fire;
  logic [N_SW-1:0]         repeat_q, repeat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= H_REL;
      end
      hold_q   <= '0;
      repeat_q <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= state_d[i];
      end
      hold_q   <= hold_d;
      repeat_q <= repeat_d;
    end
  end

  // Release is checked before the repeat count so a coinciding release suppresses the repeat.
  always_comb begin
    hold_d   = hold_q;
    rep_fire = '0;
    for (int i = 0; i < N_SW; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        H_REL: begin
          if (press_d[i]) begin
            state_d[i] = H_WAIT;
            hold_d[i]  = '0;
          end else begin
            state_d[i] = H_REL;
          end
        end
        H_WAIT: begin
          if (release_d[i]) begin
            state_d[i] = H_REL;
            hold_d[i]  = '0;
          end else if (tick) begin
            if (hold_q[i] == DLY_LAST) begin
              rep_fire[i] = 1'b1;
              hold_d[i]   = '0;
              state_d[i]  = H_RPT;
            end else begin
              hold_d[i] = hold_q[i] + HW'(1);
            end
          end else begin
            hold_d[i] = hold_q[i];
          end
        end
        H_RPT: begin
          if (release_d[i]) begin
            state_d[i] = H_REL;
            hold_d[i]  = '0;
          end else if (tick) begin
            if (hold_q[i] == PER_LAST) begin
              rep_fire[i] = 1'b1;
              hold_d[i]   = '0;
            end else begin
              hold_d[i] = hold_q[i] + HW'(1);
            end
          end else begin
            hold_d[i] = hold_q[i];
          end
        end
        default: begin
          state_d[i] = H_REL;
          hold_d[i]  = '0;
        end
      endcase
    end
  end

  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (state_q[i] != H_REL) begin
        repeat_d[i] = rep_fire[i];
      end else begin
        repeat_d[i] = 1'b0;
      end
    end
  end

  assign o_repeat = repeat_q;
`else
  assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_btn_cond.sv
// Randomised bench for btn_cond against a tick-level behavioural model (sample runs, hold age).
module tb_btn_cond;
  localparam int N  = 3;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RP = 2;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] i_sw = 3'b111;
  logic [N-1:0] o_level, o_press, o_release, o_repeat;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] m_hist_new, m_hist_old;
  logic [N-1:0] m_level, m_press, m_rel, m_rep;
  int           m_edges;
  int           m_diff [N];
  int           m_held [N];
  int           obs_press [N];
  int           obs_rel   [N];
  int           obs_rep   [N];
  int           exp_press [N];
  int           exp_rel   [N];
  int           exp_rep   [N];

  always #5 clk = ~clk;

  btn_cond #(.N_SW(N), .TICK_DIV(TD), .DB_CNT(DB), .REP_DLY(RD), .REP_PER(RP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sw      (i_sw),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_repeat  (o_repeat)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rep_due(input int age);
    return (age == RD) || ((age > RD) && (((age - RD) % RP) == 0));
  endfunction

  task automatic model_reset();
    m_hist_new = '1;
    m_hist_old = '1;
    m_edges    = 0;
    m_level    = '0;
    m_press    = '0;
    m_rel      = '0;
    m_rep      = '0;
    for (int c = 0; c < N; c++) begin
      m_diff[c] = 0;
      m_held[c] = -1;
    end
  endtask

  // Expected outputs after the coming clock edge, given the currently driven i_sw.
  task automatic model_edge();
    logic [N-1:0] s;
    bit tick;
    s          = ~m_hist_old;
    tick       = ((m_edges % TD) == TD - 1);
    m_edges++;
    m_hist_old = m_hist_new;
    m_hist_new = i_sw;
    m_press    = '0;
    m_rel      = '0;
    m_rep      = '0;
    if (tick) begin
      for (int c = 0; c < N; c++) begin
        if (s[c] != m_level[c]) begin
          m_diff[c]++;
          if (m_diff[c] == DB) begin
            m_diff[c]  = 0;
            m_level[c] = s[c];
            if (s[c]) m_press[c] = 1'b1;
            else      m_rel[c]   = 1'b1;
          end
        end else begin
          m_diff[c] = 0;
        end
        if (m_press[c]) begin
          m_held[c] = 0;
        end else if (m_rel[c]) begin
          m_held[c] = -1;
        end else if (m_held[c] >= 0) begin
          m_held[c]++;
          if (REP_EN && rep_due(m_held[c])) m_rep[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("level",   o_level,   m_level);
    check_eq("press",   o_press,   m_press);
    check_eq("release", o_release, m_rel);
    check_eq("repeat",  o_repeat,  m_rep);
    for (int c = 0; c < N; c++) begin
      obs_press[c] += int'(o_press[c]);
      obs_rel[c]   += int'(o_release[c]);
      obs_rep[c]   += int'(o_repeat[c]);
      exp_press[c] += int'(m_press[c]);
      exp_rel[c]   += int'(m_rel[c]);
      exp_rep[c]   += int'(m_rep[c]);
    end
  endtask

  task automatic drive_ticks(input logic [N-1:0] val, input int n_ticks);
    i_sw = val;
    repeat (n_ticks * TD) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_level"},   o_level,   3'b000);
    check_eq({tag, "_press"},   o_press,   3'b000);
    check_eq({tag, "_release"}, o_release, 3'b000);
    check_eq({tag, "_repeat"},  o_repeat,  3'b000);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  int base_p, base_r, base_q;

  initial begin
    for (int c = 0; c < N; c++) begin
      obs_press[c] = 0; obs_rel[c] = 0; obs_rep[c] = 0;
      exp_press[c] = 0; exp_rel[c] = 0; exp_rep[c] = 0;
    end
    model_reset();
    i_sw  = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    drive_ticks(3'b000, 6);
    for (int c = 0; c < N; c++) check_eq("reset_held_press_once", obs_press[c], 1);
    check_eq("reset_held_level", o_level, 3'b111);
    drive_ticks(3'b111, 8);

    base_p = obs_press[0];
    drive_ticks(3'b110, 2);
    drive_ticks(3'b111, 1);
    drive_ticks(3'b110, 2);
    drive_ticks(3'b111, 5);
    check_eq("bounce_no_press", obs_press[0] - base_p, 0);
    check_eq("bounce_level", o_level[0], 1'b0);

    base_p = obs_press[2]; base_r = obs_rel[2]; base_q = obs_rep[2];
    drive_ticks(3'b011, 20);
    drive_ticks(3'b111, 8);
    check_eq("phr_press_once", obs_press[2] - base_p, 1);
    check_eq("phr_release_once", obs_rel[2] - base_r, 1);
    check_eq("phr_repeats", obs_rep[2] - base_q, REP_EN ? 8 : 0);

    for (int h = 8; h <= 13; h++) begin
      drive_ticks(3'b101, h);
      drive_ticks(3'b111, 6);
    end

    drive_ticks(3'b101, 12);
    base_p = obs_press[1];
    do_reset();
    drive_ticks(3'b101, 12);
    check_eq("rst_mid_rpt_fresh_press", obs_press[1] - base_p, 1);
    drive_ticks(3'b111, 6);

    for (int ph = 0; ph < 2; ph++) begin
      repeat (1500) begin
        if ($urandom_range(0, (ph == 0) ? 5 : 40) == 0) begin
          int idx;
          idx = $urandom_range(0, N - 1);
          i_sw[idx] = ~i_sw[idx];
        end
        step();
      end
    end
    drive_ticks(3'b111, 8);

    for (int c = 0; c < N; c++) begin
      check_eq("total_press", obs_press[c], exp_press[c]);
      check_eq("total_release", obs_rel[c], exp_rel[c]);
      check_eq("total_repeat", obs_rep[c], exp_rep[c]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
